tdm_mux4_tx: RTL

TDM_MUX4_TX -- requirements
Module: tdm_mux4_tx

---
 rtl/tdm_mux4_tx_if.sv | 20 ++
 rtl/tdm_mux4_tx.sv | 87 ++++++++
 2 files changed

// File: rtl/tdm_mux4_tx_if.sv
// tdm_mux4_tx_if -- bus between a data source and the 4-channel TDM transmitter.
//   en         : transmit enable (source -> tx)
//   d[3:0]     : channel data, d[i] = channel i (source -> tx)
//   q          : serial TDM line (tx -> sink)
//   s[1:0]     : current slot index, demux select (tx -> sink)
//   frame      : high for every cycle of slot 0 while sending (tx -> sink)
//   busy       : high while loading or sending (tx -> sink)
//   frame_done : one-cycle pulse on the last cycle of slot 3 (tx -> sink)
interface tdm_mux4_tx_if;
  logic       en;
  logic [3:0] d;
  logic       q;
  logic [1:0] s;
  logic       frame;
  logic       busy;
  logic       frame_done;

  modport master (output en, d, input q, s, frame, busy, frame_done);
  modport slave  (input en, d, output q, s, frame, busy, frame_done);
endinterface

// File: rtl/tdm_mux4_tx.sv
// tdm_mux4_tx -- time-division multiplexer for four 1-bit channels.
// Each frame is four slots of SLOT_CYCLES clocks. The four data bits are captured
// into a shadow register at frame start and are then sent one slot at a time.
//   clk : sole clock, rising edge
//   rst : synchronous active-high reset
//   bus : tdm_mux4_tx_if.slave (en, d in; q, s, frame, busy, frame_done out)
module tdm_mux4_tx #(
  parameter int unsigned SLOT_CYCLES = 4
) (
  input  logic          clk,
  input  logic          rst,
  tdm_mux4_tx_if.slave  bus
);

  localparam int unsigned PW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [PW-1:0] PRE_TC = PW'(SLOT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } state_t;

  state_t        state_q;
  logic [3:0]    shadow_q;
  logic [1:0]    slot_q;
  logic [PW-1:0] pre_q;

  logic pre_tc;
  assign pre_tc = (pre_q == PRE_TC);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      slot_q   <= '0;
      pre_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.en) state_q <= LOAD;
        end
        LOAD: begin
          shadow_q <= bus.d;
          slot_q   <= '0;
          pre_q    <= '0;
          state_q  <= SEND;
        end
        SEND: begin
          if (pre_tc) begin
            pre_q  <= '0;
            // slot wraps 3 -> 0 on its own, which covers both frame-end cases
            slot_q <= slot_q + 2'd1;
            if (slot_q == 2'd3) begin
              if (bus.en) shadow_q <= bus.d;
              else        state_q  <= IDLE;
            end
          end else begin
            pre_q <= pre_q + PW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Outputs depend only on registered state; d and en never reach them directly.
  always_comb begin
    bus.q          = 1'b0;
    bus.s          = '0;
    bus.frame      = 1'b0;
    bus.busy       = 1'b0;
    bus.frame_done = 1'b0;
    case (state_q)
      LOAD: bus.busy = 1'b1;
      SEND: begin
        bus.q          = shadow_q[slot_q];
        bus.s          = slot_q;
        bus.frame      = (slot_q == 2'd0);
        bus.busy       = 1'b1;
        bus.frame_done = pre_tc && (slot_q == 2'd3);
      end
      default: ;
    endcase
  end

endmodule
